// File: rtl/demux_buf_pkg.sv
// Shared constants and helpers for the demux_buf block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_buf_pkg;

  // Default payload width and per-output FIFO depth.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Discard counter width and its saturation ceiling.
  localparam int              DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Saturating increment: the counter sticks at DROP_CNT_MAX instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    r = v;
    if (v != DROP_CNT_MAX) begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_buf_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is presented whenever not empty.
// Latency: a push is visible at head_o/empty_o one cycle after the write edge.
// Backpressure: full_o comes from the registered count only; pushes while full are ignored.
module sync_fifo
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH for free;
  // the count needs one extra bit to represent DEPTH itself.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Full/empty are pure functions of the registered count, so a full FIFO
  // cannot accept a push even when its head leaves in the same cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Head entry is read straight from storage: no bypass from the write port.
  assign head_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while empty so it has no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/demux_buf.sv
// Routes each input beat to one of two buffered outputs (s selects y0/y1), or discards it when e=0.
// Latency: 1 cycle from input transfer to output valid; no combinational bypass.
// Backpressure: i_ready follows the selected FIFO's full flag; discards always accepted.
// Optional feature: define DEMUX_BUF_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_buf
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             s,
  input  logic             e,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_BUF_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic full0, full1;
  logic empty0, empty1;
  logic sel_full;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Readiness depends only on the routing controls and registered FIFO state,
  // never on payload; a disabled beat is always swallowed.
  assign sel_full = s ? full1 : full0;
  assign i_ready  = e ? ~sel_full : 1'b1;
  assign accept   = i_valid & i_ready;

  // Only the selected FIFO sees a push, so the two outputs stay independent.
  assign push0 = accept & e & ~s;
  assign push1 = accept & e & s;

  assign y0_valid = ~empty0;
  assign y1_valid = ~empty1;
  assign pop0     = y0_valid & y0_ready;
  assign pop1     = y1_valid & y1_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push0),
    .push_data_i (i_data),
    .pop_i       (pop0),
    .full_o      (full0),
    .empty_o     (empty0),
    .head_o      (y0_data)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push1),
    .push_data_i (i_data),
    .pop_i       (pop1),
    .full_o      (full1),
    .empty_o     (empty1),
    .head_o      (y1_data)
  );

`ifdef DEMUX_BUF_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Count every accepted beat that was discarded because routing was disabled.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept & ~e) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Discard counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Self-checking bench for demux_buf: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_demux_buf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_ready;
  logic             s;
  logic             e;
  logic [WIDTH-1:0] y0_data;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1_data;
  logic             y1_valid;
  logic             y1_ready;
`ifdef DEMUX_BUF_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  always #5 clk = ~clk;

  demux_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .s        (s),
    .e        (e),
    .y0_data  (y0_data),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready)
`ifdef DEMUX_BUF_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv, s, e;
    logic [7:0] d;
    logic       r0, r1;
    logic       exp_rdy;
    logic       exp_v0;
    logic [7:0] exp_d0;
    logic       exp_v1;
    logic [7:0] exp_d1;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic sel, input logic en, input logic [7:0] d,
                              input logic r0, input logic r1, input logic er,
                              input logic ev0, input logic [7:0] ed0,
                              input logic ev1, input logic [7:0] ed1);
    vec_t v;
    v.iv = iv; v.s = sel; v.e = en; v.d = d; v.r0 = r0; v.r1 = r1;
    v.exp_rdy = er; v.exp_v0 = ev0; v.exp_d0 = ed0; v.exp_v1 = ev1; v.exp_d1 = ed1;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic sel, input logic en, input logic [7:0] d,
                       input logic r0, input logic r1);
    i_valid = iv; s = sel; e = en; i_data = d; y0_ready = r0; y1_ready = r1;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference model state.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         drops;

  vec_t       tbl[17];
  logic [7:0] got[$];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    #1;
    chk("reset_y0_valid", y0_valid, 0);
    chk("reset_y1_valid", y1_valid, 0);
    chk("reset_i_ready", i_ready, 1);
`ifdef DEMUX_BUF_DROP_CNT_EN
    chk("reset_drop_cnt", drop_cnt, 0);
`endif

    // ---------------- directed vector table ----------------
    tbl[0]  = mk(1, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[1]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 1, 8'hA1, 0, 8'h00);
    tbl[2]  = mk(1, 1, 1, 8'h10, 0, 0, 1, 1, 8'hA1, 0, 8'h00);
    tbl[3]  = mk(1, 1, 1, 8'h11, 0, 0, 1, 1, 8'hA1, 1, 8'h10);
    tbl[4]  = mk(1, 1, 1, 8'h12, 0, 0, 1, 1, 8'hA1, 1, 8'h10);
    tbl[5]  = mk(1, 1, 1, 8'h13, 0, 0, 1, 1, 8'hA1, 1, 8'h10);
    tbl[6]  = mk(1, 1, 1, 8'h14, 0, 0, 0, 1, 8'hA1, 1, 8'h10);
    tbl[7]  = mk(1, 0, 1, 8'h55, 1, 0, 1, 1, 8'hA1, 1, 8'h10);
    tbl[8]  = mk(0, 1, 1, 8'h00, 1, 0, 0, 1, 8'h55, 1, 8'h10);
    tbl[9]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00, 1, 8'h10);
    tbl[10] = mk(1, 1, 1, 8'h20, 0, 1, 0, 0, 8'h00, 1, 8'h10);
    tbl[11] = mk(1, 1, 1, 8'h20, 0, 0, 1, 0, 8'h00, 1, 8'h11);
    tbl[12] = mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 8'h00, 1, 8'h11);
    tbl[13] = mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 8'h00, 1, 8'h12);
    tbl[14] = mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 8'h00, 1, 8'h13);
    tbl[15] = mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 8'h00, 1, 8'h20);
    tbl[16] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h00);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d_i_ready", i), i_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_y0_valid", i), y0_valid, tbl[i].exp_v0);
      chk($sformatf("tbl%0d_y1_valid", i), y1_valid, tbl[i].exp_v1);
      if (tbl[i].exp_v0) chk($sformatf("tbl%0d_y0_data", i), y0_data, tbl[i].exp_d0);
      if (tbl[i].exp_v1) chk($sformatf("tbl%0d_y1_data", i), y1_data, tbl[i].exp_d1);
      @(posedge clk);
      #1;
    end

    // ---------------- e=0: three beats discarded ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
      #1;
      chk($sformatf("drop%0d_i_ready", i), i_ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("drop%0d_y0_valid", i), y0_valid, 0);
      chk($sformatf("drop%0d_y1_valid", i), y1_valid, 0);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("drop_after_y0_valid", y0_valid, 0);
    chk("drop_after_y1_valid", y1_valid, 0);
`ifdef DEMUX_BUF_DROP_CNT_EN
    chk("drop_cnt_3", drop_cnt, 3);
    // Saturation at 255.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (260) @(posedge clk);
    #1;
    chk("drop_cnt_sat", drop_cnt, 255);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`endif

    // ---------------- reset mid-operation ----------------
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h71, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 8'h72, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rst_mid_pre_y0_valid", y0_valid, 1);
    chk("rst_mid_pre_y0_data", y0_data, 8'h71);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_y0_valid", y0_valid, 0);
    chk("rst_mid_i_ready", i_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    y0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_post%0d_y0_valid", i), y0_valid, 0);
      chk($sformatf("rst_post%0d_y1_valid", i), y1_valid, 0);
    end

    // ---------------- ordered stream into y0 with random ready ----------------
    begin
      int tx;
      tx = 0;
      got.delete();
      for (int cyc = 0; cyc < 300 && got.size() < 10; cyc++) begin
        drive(tx < 10, 1'b0, 1'b1, 8'h30 + 8'(tx), 1'($urandom % 2), 1'b0);
        #1;
        if (y0_valid && y0_ready) got.push_back(y0_data);
        if (i_valid && i_ready) tx++;
        @(posedge clk);
        #1;
      end
      drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("stream_count", got.size(), 10);
      for (int i = 0; i < got.size() && i < 10; i++) begin
        chk($sformatf("stream%0d_data", i), got[i], 8'h30 + 8'(i));
      end
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    q0.delete();
    q1.delete();
    drops = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic exp_rdy, do_push0, do_push1, do_pop0, do_pop1;
      drive(1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0, 8'($urandom),
            1'($urandom % 2), ($urandom % 3) != 0);
      #1;
      if (e) exp_rdy = (s ? q1.size() : q0.size()) < DEPTH;
      else   exp_rdy = 1'b1;
      chk("rnd_i_ready", i_ready, exp_rdy);
      chk("rnd_y0_valid", y0_valid, q0.size() != 0);
      chk("rnd_y1_valid", y1_valid, q1.size() != 0);
      if (q0.size() != 0) chk("rnd_y0_data", y0_data, q0[0]);
      if (q1.size() != 0) chk("rnd_y1_data", y1_data, q1[0]);
`ifdef DEMUX_BUF_DROP_CNT_EN
      chk("rnd_drop_cnt", drop_cnt, drops);
`endif
      do_pop0  = y0_ready && q0.size() != 0;
      do_pop1  = y1_ready && q1.size() != 0;
      do_push0 = i_valid && exp_rdy && e && !s;
      do_push1 = i_valid && exp_rdy && e && s;
      if (do_pop0) void'(q0.pop_front());
      if (do_pop1) void'(q1.pop_front());
      if (do_push0) q0.push_back(i_data);
      if (do_push1) q1.push_back(i_data);
      if (i_valid && !e && drops < 255) drops++;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
